// File: rtl/serial_mac_accumulator_if.sv
// ---------------------------------------------------------------------------
// serial_mac_accumulator_if
// Bundles the loader-side pair stream and the result handshake of the
// serial MAC accumulator.
//
// Signals
//   w_in      : signed weight operand (loader w_out)
//   f_in      : signed feature operand (loader f_out)
//   acc_en    : pair valid this cycle
//   clr       : window abort / clear (loader rst_pe)
//   out_valid : window result valid
//   out_ready : consumer accepts result
//   out_data  : signed window result
//   out_addr  : output buffer write address for out_data
//   out_we    : out_valid & out_ready
//
// Modports
//   master : loader + result consumer side (drives pairs and out_ready)
//   slave  : accumulator side
// ---------------------------------------------------------------------------
interface serial_mac_accumulator_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int OUT_AW = 6
);
  logic [DATA_W-1:0] w_in;
  logic [DATA_W-1:0] f_in;
  logic              acc_en;
  logic              clr;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic [OUT_AW-1:0] out_addr;
  logic              out_we;

  modport master (
    output w_in, f_in, acc_en, clr, out_ready,
    input  out_valid, out_data, out_addr, out_we
  );

  modport slave (
    input  w_in, f_in, acc_en, clr, out_ready,
    output out_valid, out_data, out_addr, out_we
  );
endinterface

// File: rtl/serial_mac_accumulator.sv
// ---------------------------------------------------------------------------
// serial_mac_accumulator
// Signed multiply-accumulate over NUM_TAPS accepted weight/feature pairs.
// The finished window sum is held on a valid/ready handshake together with
// an output buffer write address that advances once per delivered window.
//
// Ports
//   clk_i          : clock, all state updates on the rising edge
//   rst_i          : synchronous active-high reset, overrides all inputs
//   out_baseaddr_i : first output address, sampled only while rst_i is high
//   bus            : pair stream + result handshake (slave modport)
//   busy_o         : high while accumulating or holding a result
//   overrun_o      : sticky, a pair arrived while a result was pending
//   tap_cnt_o      : taps accepted in the current window
//
// Optional build macro
//   SERIAL_MAC_RELU_EN : when defined, the value latched into out_data is
//                        clamped to max(sum, 0); the accumulator is unchanged.
//
// States
//   IDLE | no window in progress, waiting for the first pair
//   ACC  | window in progress, accumulating pairs
//   HOLD | window complete, result presented until accepted
// ---------------------------------------------------------------------------
module serial_mac_accumulator #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 20,
  parameter int NUM_TAPS = 9,
  parameter int OUT_AW   = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [OUT_AW-1:0]        out_baseaddr_i,
  serial_mac_accumulator_if.slave  bus,
  output logic                     busy_o,
  output logic                     overrun_o,
  output logic [3:0]               tap_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam logic [3:0] TAPS_L = 4'(NUM_TAPS);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [3:0]        tap_q, tap_d;
  logic [ACC_W-1:0]  out_data_q, out_data_d;
  logic [OUT_AW-1:0] out_addr_q, out_addr_d;
  logic              overrun_q, overrun_d;

  logic signed [DATA_W-1:0]   w_s;
  logic signed [DATA_W-1:0]   f_s;
  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]           prod_ext;
  logic [ACC_W-1:0]           win_sum;
  logic [ACC_W-1:0]           result;
  logic [3:0]                 tap_inc;

  assign w_s      = signed'(bus.w_in);
  assign f_s      = signed'(bus.f_in);
  assign prod     = w_s * f_s;
  assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign tap_inc  = tap_q + 4'd1;

  // Sum including the pair arriving this cycle; in IDLE the window starts fresh.
  assign win_sum = (state_q == S_IDLE) ? prod_ext : (acc_q + prod_ext);

`ifdef SERIAL_MAC_RELU_EN
  assign result = win_sum[ACC_W-1] ? '0 : win_sum;
`else
  assign result = win_sum;
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    tap_d      = tap_q;
    out_data_d = out_data_q;
    out_addr_d = out_addr_q;
    overrun_d  = overrun_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.clr) begin
          acc_d = '0;
          tap_d = '0;
        end else if (bus.acc_en) begin
          acc_d = win_sum;
          tap_d = 4'd1;
          if (TAPS_L == 4'd1) begin
            out_data_d = result;
            state_d    = S_HOLD;
          end else begin
            state_d    = S_ACC;
          end
        end
      end

      S_ACC: begin
        // clr beats a simultaneous pair; the pair is discarded.
        if (bus.clr) begin
          acc_d   = '0;
          tap_d   = '0;
          state_d = S_IDLE;
        end else if (bus.acc_en) begin
          acc_d = win_sum;
          tap_d = tap_inc;
          if (tap_inc == TAPS_L) begin
            out_data_d = result;
            state_d    = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        // clr is ignored here so a pending result cannot be lost.
        if (bus.acc_en) begin
          overrun_d = 1'b1;
        end
        if (bus.out_ready) begin
          out_addr_d = out_addr_q + 1'b1;
          acc_d      = '0;
          tap_d      = '0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        acc_d   = '0;
        tap_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      tap_q      <= '0;
      out_data_q <= '0;
      out_addr_q <= out_baseaddr_i;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      tap_q      <= tap_d;
      out_data_q <= out_data_d;
      out_addr_q <= out_addr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.out_valid = (state_q == S_HOLD);
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_we    = (state_q == S_HOLD) & bus.out_ready;
  assign busy_o        = (state_q != S_IDLE);
  assign overrun_o     = overrun_q;
  assign tap_cnt_o     = tap_q;

endmodule

// File: tb/tb_serial_mac_accumulator.sv
module tb_serial_mac_accumulator;
  localparam int DATA_W   = 8;
  localparam int ACC_W    = 20;
  localparam int NUM_TAPS = 9;
  localparam int OUT_AW   = 6;

  logic              clk;
  logic              rst;
  logic [OUT_AW-1:0] baseaddr;
  logic              busy;
  logic              overrun;
  logic [3:0]        tap_cnt;

  int checks = 0;
  int errors = 0;

  serial_mac_accumulator_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_AW(OUT_AW)) bus();

  serial_mac_accumulator #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .NUM_TAPS(NUM_TAPS), .OUT_AW(OUT_AW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .out_baseaddr_i(baseaddr),
    .bus           (bus.slave),
    .busy_o        (busy),
    .overrun_o     (overrun),
    .tap_cnt_o     (tap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input int w, input int f, input int n);
    bus.w_in   = DATA_W'(w);
    bus.f_in   = DATA_W'(f);
    bus.acc_en = 1'b1;
    for (int i = 0; i < n; i++) step();
    bus.acc_en = 1'b0;
  endtask

  logic [ACC_W-1:0] exp_neg;

  initial begin
    rst           = 1'b1;
    baseaddr      = 6'h10;
    bus.w_in      = '0;
    bus.f_in      = '0;
    bus.acc_en    = 1'b0;
    bus.clr       = 1'b0;
    bus.out_ready = 1'b1;
`ifdef SERIAL_MAC_RELU_EN
    exp_neg = '0;
`else
    exp_neg = ACC_W'(-315);
`endif

    // reset
    step();
    rst = 1'b0;
    chk("rst_valid",   32'(bus.out_valid), 32'd0);
    chk("rst_addr",    32'(bus.out_addr),  32'h10);
    chk("rst_tap",     32'(tap_cnt),       32'd0);
    chk("rst_overrun", 32'(overrun),       32'd0);
    chk("rst_busy",    32'(busy),          32'd0);
    chk("rst_data",    32'(bus.out_data),  32'd0);

    // 3*2 x9 = 54
    feed(3, 2, 8);
    chk("w1_tap8",  32'(tap_cnt),       32'd8);
    chk("w1_nv8",   32'(bus.out_valid), 32'd0);
    feed(3, 2, 1);
    chk("w1_valid", 32'(bus.out_valid), 32'd1);
    chk("w1_data",  32'(bus.out_data),  32'd54);
    chk("w1_we",    32'(bus.out_we),    32'd1);
    chk("w1_addr",  32'(bus.out_addr),  32'h10);
    chk("w1_tap9",  32'(tap_cnt),       32'd9);
    step();
    chk("w1_done_valid", 32'(bus.out_valid), 32'd0);
    chk("w1_done_we",    32'(bus.out_we),    32'd0);
    chk("w1_done_addr",  32'(bus.out_addr),  32'h11);
    chk("w1_done_tap",   32'(tap_cnt),       32'd0);
    chk("w1_done_busy",  32'(busy),          32'd0);

    // -128*-128 x9 = 147456
    feed(-128, -128, 9);
    chk("w2_data", 32'(bus.out_data), 32'd147456);
    step();
    chk("w2_addr", 32'(bus.out_addr), 32'h12);

    // -5*7 x9 = -315 (0 with ReLU)
    feed(-5, 7, 9);
    chk("w3_valid", 32'(bus.out_valid), 32'd1);
    chk("w3_data",  32'(bus.out_data),  32'(exp_neg));
    step();
    chk("w3_addr",  32'(bus.out_addr),  32'h13);

    // back-pressure with dropped pairs: 1*4 x9 = 36
    bus.out_ready = 1'b0;
    feed(1, 4, 9);
    bus.w_in = 8'd7;
    for (int i = 0; i < 5; i++) begin
      bus.acc_en = (i % 2 == 0);
      step();
    end
    bus.acc_en = 1'b0;
    chk("bp_valid",   32'(bus.out_valid), 32'd1);
    chk("bp_we",      32'(bus.out_we),    32'd0);
    chk("bp_data",    32'(bus.out_data),  32'd36);
    chk("bp_tap",     32'(tap_cnt),       32'd9);
    chk("bp_overrun", 32'(overrun),       32'd1);
    chk("bp_addr",    32'(bus.out_addr),  32'h13);
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    chk("bp_clr_ignored", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_we_rel", 32'(bus.out_we), 32'd1);
    step();
    chk("bp_idle",        32'(busy),          32'd0);
    chk("bp_addr_adv",    32'(bus.out_addr),  32'h14);
    chk("bp_overrun_stk", 32'(overrun),       32'd1);

    // clr mid-window with simultaneous pair
    feed(2, 2, 4);
    chk("clr_tap4", 32'(tap_cnt), 32'd4);
    chk("clr_busy", 32'(busy),    32'd1);
    bus.clr    = 1'b1;
    bus.acc_en = 1'b1;
    step();
    bus.clr    = 1'b0;
    bus.acc_en = 1'b0;
    chk("clr_tap0", 32'(tap_cnt),      32'd0);
    chk("clr_idle", 32'(busy),         32'd0);
    chk("clr_addr", 32'(bus.out_addr), 32'h14);
    feed(1, 1, 9);
    chk("clr_next_data", 32'(bus.out_data), 32'd9);
    step();

    // address wrap from 0x3F
    baseaddr = 6'h3F;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("wrap_rst_addr",    32'(bus.out_addr), 32'h3F);
    chk("wrap_rst_overrun", 32'(overrun),      32'd0);
    feed(1, 1, 9);
    chk("wrap_addr0", 32'(bus.out_addr), 32'h3F);
    step();
    chk("wrap_addr1", 32'(bus.out_addr), 32'h00);
    feed(2, 3, 9);
    chk("wrap_data2", 32'(bus.out_data), 32'd54);
    chk("wrap_addr2", 32'(bus.out_addr), 32'h00);
    step();
    chk("wrap_addr3", 32'(bus.out_addr), 32'h01);

    // rst mid-window
    feed(1, 1, 5);
    chk("mid_tap5", 32'(tap_cnt), 32'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_tap",   32'(tap_cnt),       32'd0);
    chk("mid_busy",  32'(busy),          32'd0);
    chk("mid_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_data",  32'(bus.out_data),  32'd0);
    chk("mid_addr",  32'(bus.out_addr),  32'h3F);

    // rst while holding a result
    bus.out_ready = 1'b0;
    feed(1, 1, 9);
    chk("hold_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("hold_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("hold_rst_data",  32'(bus.out_data),  32'd0);
    chk("hold_rst_tap",   32'(tap_cnt),       32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_mac_accumulator.md
Name: serial_mac_accumulator

Overview:
- Downstream stage of the serial data loader; consumes its serialized weight/feature pairs (w_out, f_out, acc_en, rst_pe).
- Performs a signed multiply-accumulate over NUM_TAPS accepted pairs (one 3x3 window = 9 taps) and presents the window result on a valid/ready handshake.
- Generates a write address into the output buffer that advances per completed window.

Parameters:
- DATA_W, 8, width of weight and feature operands (two's complement)
- ACC_W, 20, accumulator width; must be ≥ 2*DATA_W + ceil(log2(NUM_TAPS))
- NUM_TAPS, 9, accepted pairs per window
- OUT_AW, 6, output buffer address width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- w_in  in  DATA_W  signed weight (loader w_out)
- f_in  in  DATA_W  signed feature (loader f_out)
- acc_en  in  1  pair valid this cycle (loader acc_en)
- clr  in  1  synchronous window abort/clear (loader rst_pe)
- out_baseaddr  in  OUT_AW  first output address; sampled only on rst
- out_valid  out  1  window result valid
- out_ready  in  1  consumer accepts result
- out_data  out  ACC_W  signed window result
- out_addr  out  OUT_AW  write address for out_data
- out_we  out  1  equals out_valid & out_ready
- busy  out  1  high in ACC or HOLD
- overrun  out  1  sticky; pair dropped while in HOLD
- tap_cnt  out  4  taps accepted in the current window

Behaviour:
- Reset: synchronous, active-high; overrides all inputs. State=IDLE, acc=0, tap_cnt=0, out_valid=0, out_data=0, out_we=0, busy=0, overrun=0, out_addr=out_baseaddr.
- Product: signed DATA_W x DATA_W, sign-extended to ACC_W. Accumulate is wrap-around two's complement (no saturation inside the accumulator).
- FSM states: IDLE, ACC, HOLD.
- IDLE:
  - acc_en=1: acc=product, tap_cnt=1, go to ACC.
  - If NUM_TAPS==1, go directly to HOLD instead.
- ACC:
  - acc_en=1: acc+=product, tap_cnt+=1.
  - When the accepted tap makes tap_cnt==NUM_TAPS: out_data=acc+product, go to HOLD.
  - acc_en=0: hold all state.
- HOLD:
  - out_valid=1; out_data and out_addr stable until handshake.
  - out_valid & out_ready: out_we=1 that cycle. Next edge: out_addr+=1 (wraps at 2^OUT_AW−1 → 0), acc=0, tap_cnt=0, go to IDLE.
  - acc_en=1 in HOLD: pair dropped, overrun=1 (sticky until rst).
- Latency: result visible (out_valid=1) the cycle after the edge that accepted the NUM_TAPS-th pair. With out_ready tied high, out_we pulses for exactly one cycle.
- clr:
  - In IDLE/ACC: acc=0, tap_cnt=0, go to IDLE; out_addr unchanged.
  - clr and acc_en in the same cycle: clr wins, pair discarded.
  - clr in HOLD: ignored. A pending result is never lost except by rst.
- rst mid-window or during HOLD: result discarded, all registers return to reset values.
- busy = (state != IDLE).
- out_we is combinational from registered out_valid and the out_ready input. All other outputs are registered.

Optional Feature:
- Macro: SERIAL_MAC_RELU_EN.
- Defined: the value latched into out_data on the IDLE/ACC→HOLD transition is max(result, 0). Negative window sums yield out_data=0. The accumulator itself is unaffected.
- Undefined: out_data is the raw signed sum. No extra logic is synthesized.

Test Plan:
- rst high 1 cycle with out_baseaddr=0x10 → next cycle: out_valid=0, out_addr=0x10, tap_cnt=0, overrun=0.
- Nine pairs w=3, f=2, acc_en=1 back-to-back, out_ready=1 → out_valid high one cycle after the 9th pair, out_data=54, out_we=1, out_addr=0x10, then 0x11.
- Nine pairs w=−128, f=−128 → out_data=147456; with w=−5, f=7 → out_data=−315 (or 0 with SERIAL_MAC_RELU_EN).
- Window complete, out_ready=0 for 5 cycles while acc_en=1 pulses → out_data held stable, overrun=1, tap_cnt stays 9; out_ready=1 → out_we=1 and return to IDLE.
- Four pairs accepted, then clr=1 together with acc_en=1 → tap_cnt=0, state IDLE, out_addr unchanged; a following full window of w=1, f=1 gives out_data=9.
- out_baseaddr=0x3F, complete two windows → out_addr 0x3F then wraps to 0x00. rst asserted mid-window → all outputs return to reset values the next cycle.
